// File: rtl/circuit4_operand_issue.sv
// Operand feed for the Circuit4 datapath: FIFO-buffered a/b/c triples,
// issued one per cycle, with a valid/tag delay line tracking result latency.
//
// Ports:
//   Clk, Rst                  clock, synchronous active-high reset
//   in_valid/in_ready         producer handshake; in_a/in_b/in_c triple
//   issue_en                  allow a pop/issue this cycle
//   a, b, c                   registered operands driven to the datapath
//   iss_valid, iss_tag        a/b/c loaded at the last edge, and its tag
//   res_valid, res_tag        datapath x/z carry the result for res_tag
//   level                     FIFO occupancy, 0..DEPTH
module circuit4_operand_issue #(
  parameter  int DATAWIDTH = 64,
  parameter  int DEPTH     = 4,
  parameter  int LATENCY   = 2,
  parameter  int TAGW      = 4,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_a,
  input  logic [DATAWIDTH-1:0] in_b,
  input  logic [DATAWIDTH-1:0] in_c,
  input  logic                 issue_en,
  output logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] c,
  output logic                 iss_valid,
  output logic [TAGW-1:0]      iss_tag,
  output logic                 res_valid,
  output logic [TAGW-1:0]      res_tag,
  output logic [LW-1:0]        level
);

  typedef struct packed {
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic [DATAWIDTH-1:0] c;
  } triple_t;

  triple_t             mem_q [DEPTH];
  logic [AW-1:0]       wptr_q, wptr_d;
  logic [AW-1:0]       rptr_q, rptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [TAGW-1:0]     tag_q, tag_d;
  triple_t             ops_q, ops_d;
  logic                iss_valid_q, iss_valid_d;
  logic [TAGW-1:0]     iss_tag_q, iss_tag_d;
  logic [LATENCY-1:0]  dl_v_q;
  logic [TAGW-1:0]     dl_t_q [LATENCY];
  logic                push, pop;
  triple_t             head;

  // Readiness uses registered level only: a same-cycle pop
  // never frees a slot early.
  assign in_ready = (level_q < LW'(DEPTH)) && !Rst;

  always_comb begin
    push        = in_valid && in_ready;
    pop         = (level_q != '0) && issue_en;
    head        = mem_q[rptr_q];
    wptr_d      = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d      = pop ? rptr_q + AW'(1) : rptr_q;
    tag_d       = pop ? tag_q + TAGW'(1) : tag_q;
    ops_d       = pop ? head : ops_q;
    iss_valid_d = pop;
    iss_tag_d   = pop ? tag_q : iss_tag_q;
    level_d     = level_q;
    if (push && !pop) level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[wptr_q] <= '{a: in_a, b: in_b, c: in_c};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      tag_q       <= '0;
      ops_q       <= '0;
      iss_valid_q <= 1'b0;
      iss_tag_q   <= '0;
      dl_v_q      <= '0;
      for (int i = 0; i < LATENCY; i++) dl_t_q[i] <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      tag_q       <= tag_d;
      ops_q       <= ops_d;
      iss_valid_q <= iss_valid_d;
      iss_tag_q   <= iss_tag_d;
      // Free-running shift: mirrors the datapath's unstalled registers.
      dl_v_q[0]   <= iss_valid_q;
      dl_t_q[0]   <= iss_tag_q;
      for (int i = 1; i < LATENCY; i++) begin
        dl_v_q[i] <= dl_v_q[i-1];
        dl_t_q[i] <= dl_t_q[i-1];
      end
    end
  end

  assign a         = ops_q.a;
  assign b         = ops_q.b;
  assign c         = ops_q.c;
  assign iss_valid = iss_valid_q;
  assign iss_tag   = iss_tag_q;
  assign res_valid = dl_v_q[LATENCY-1];
  assign res_tag   = dl_t_q[LATENCY-1];
  assign level     = level_q;

endmodule

// File: tb/tb_circuit4_operand_issue.sv
// Bench for circuit4_operand_issue: directed vector table plus
// hand-written full-FIFO, tag-wrap and mid-run reset sequences.
module tb_circuit4_operand_issue;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        in_valid, in_ready, issue_en;
  logic [63:0] in_a, in_b, in_c;
  logic [63:0] a, b, c;
  logic        iss_valid, res_valid;
  logic [3:0]  iss_tag, res_tag;
  logic [2:0]  level;

  int pass_cnt = 0;
  int total    = 0;

  circuit4_operand_issue dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .issue_en(issue_en),
    .a(a), .b(b), .c(c),
    .iss_valid(iss_valid), .iss_tag(iss_tag),
    .res_valid(res_valid), .res_tag(res_tag),
    .level(level)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst, v, ie;
    logic [63:0] ia, ib, ic;
    logic        rdy;
    logic [2:0]  lvl;
    logic        iv;
    logic [63:0] ea, eb, ec;
    logic [3:0]  tag;
    logic        rv;
    logic [3:0]  rtag;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(
    input logic rst, v, ie,
    input logic [63:0] ia, ib, ic,
    input logic rdy, input logic [2:0] lvl, input logic iv,
    input logic [63:0] ea, eb, ec,
    input logic [3:0] tag, input logic rv, input logic [3:0] rtag);
    vec_t r;
    r.rst = rst; r.v = v; r.ie = ie;
    r.ia = ia; r.ib = ib; r.ic = ic;
    r.rdy = rdy; r.lvl = lvl; r.iv = iv;
    r.ea = ea; r.eb = eb; r.ec = ec;
    r.tag = tag; r.rv = rv; r.rtag = rtag;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1; in_valid = 1'b0; issue_en = 1'b0;
    tick();
    Rst = 1'b0;
  endtask

  logic [63:0] q[$];
  logic [63:0] ex;
  logic [2:0]  lvl_m;
  logic [3:0]  tag_m, t_h1, t_h2, t_now;
  logic        v_h1, v_h2, v_now, exp_rdy, psh, pp;
  int          pushed, issued;

  initial begin
    Rst = 1'b1; in_valid = 1'b0; issue_en = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;

    tbl[0]  = mk(0,1,1, 5,3,7,   1,1,0, 0,0,0,  0,0,0);
    tbl[1]  = mk(0,0,1, 0,0,0,   1,0,1, 5,3,7,  0,0,0);
    tbl[2]  = mk(0,0,1, 0,0,0,   1,0,0, 5,3,7,  0,0,0);
    tbl[3]  = mk(0,0,1, 0,0,0,   1,0,0, 5,3,7,  0,1,0);
    tbl[4]  = mk(0,0,1, 0,0,0,   1,0,0, 5,3,7,  0,0,0);
    tbl[5]  = mk(1,0,0, 0,0,0,   0,0,0, 0,0,0,  0,0,0);
    tbl[6]  = mk(0,1,0, 10,11,12, 1,1,0, 0,0,0, 0,0,0);
    tbl[7]  = mk(0,1,0, 20,21,22, 1,2,0, 0,0,0, 0,0,0);
    tbl[8]  = mk(0,1,0, 30,31,32, 1,3,0, 0,0,0, 0,0,0);
    tbl[9]  = mk(0,1,0, 40,41,42, 1,4,0, 0,0,0, 0,0,0);
    tbl[10] = mk(0,1,0, 50,51,52, 0,4,0, 0,0,0, 0,0,0);
    tbl[11] = mk(0,0,1, 0,0,0,   0,3,1, 10,11,12, 0,0,0);
    tbl[12] = mk(0,0,1, 0,0,0,   1,2,1, 20,21,22, 1,0,0);
    tbl[13] = mk(0,0,1, 0,0,0,   1,1,1, 30,31,32, 2,1,0);
    tbl[14] = mk(0,0,1, 0,0,0,   1,0,1, 40,41,42, 3,1,1);
    tbl[15] = mk(0,0,1, 0,0,0,   1,0,0, 40,41,42, 3,1,2);
    tbl[16] = mk(0,0,1, 0,0,0,   1,0,0, 40,41,42, 3,1,3);
    for (int i = 17; i < 23; i++)
      tbl[i] = mk(0,0,1, 0,0,0, 1,0,0, 40,41,42, 3,0,3);

    #1;
    chk("rst_ready", in_ready, 0);
    tick();
    tick();
    chk("rst_level", level, 0);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_a", a, 0);
    chk("rst_iss_tag", iss_tag, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_tag", res_tag, 0);
    Rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);

    for (int i = 0; i < 23; i++) begin
      Rst = tbl[i].rst; in_valid = tbl[i].v; issue_en = tbl[i].ie;
      in_a = tbl[i].ia; in_b = tbl[i].ib; in_c = tbl[i].ic;
      #1;
      chk($sformatf("v%0d_ready", i), in_ready, tbl[i].rdy);
      tick();
      chk($sformatf("v%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("v%0d_iss_valid", i), iss_valid, tbl[i].iv);
      chk($sformatf("v%0d_a", i), a, tbl[i].ea);
      chk($sformatf("v%0d_b", i), b, tbl[i].eb);
      chk($sformatf("v%0d_c", i), c, tbl[i].ec);
      chk($sformatf("v%0d_iss_tag", i), iss_tag, tbl[i].tag);
      chk($sformatf("v%0d_res_valid", i), res_valid, tbl[i].rv);
      if (tbl[i].rv)
        chk($sformatf("v%0d_res_tag", i), res_tag, tbl[i].rtag);
    end
    Rst = 1'b0;

    // Full FIFO, in_valid held, 20 triples, tags wrap 15->0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; issue_en = 1'b0;
      in_a = 64'(100 + i); in_b = 64'(1100 + i); in_c = 64'(2100 + i);
      q.push_back(64'(100 + i));
      tick();
    end
    chk("A_fill_level", level, 4);
    lvl_m = 3'd4; tag_m = '0; pushed = 4; issued = 0;
    v_h1 = 0; v_h2 = 0; t_h1 = '0; t_h2 = '0;
    for (int cyc = 0; cyc < 80 && (issued < 20 || v_h1 || v_h2); cyc++) begin
      in_valid = (pushed < 20); issue_en = 1'b1;
      in_a = 64'(100 + pushed);
      in_b = 64'(1100 + pushed);
      in_c = 64'(2100 + pushed);
      #1;
      exp_rdy = (lvl_m < 3'd4);
      chk("A_ready", in_ready, exp_rdy);
      psh = in_valid && exp_rdy;
      pp  = (lvl_m != 0);
      tick();
      chk("A_res_valid", res_valid, v_h2);
      if (v_h2) chk("A_res_tag", res_tag, t_h2);
      v_now = 0; t_now = t_h1;
      if (pp) begin
        ex = q.pop_front();
        chk("A_a", a, ex);
        chk("A_b", b, ex + 1000);
        chk("A_c", c, ex + 2000);
        chk("A_iss_tag", iss_tag, tag_m);
        v_now = 1; t_now = tag_m;
        tag_m = tag_m + 4'd1;
        issued++;
      end
      chk("A_iss_valid", iss_valid, v_now);
      if (psh) begin
        q.push_back(in_a);
        pushed++;
      end
      if (psh && !pp) lvl_m = lvl_m + 3'd1;
      else if (pp && !psh) lvl_m = lvl_m - 3'd1;
      chk("A_level", level, lvl_m);
      v_h2 = v_h1; t_h2 = t_h1;
      v_h1 = v_now; t_h1 = t_now;
    end
    chk("A_issued", issued, 20);
    chk("A_final_tag", tag_m, 4);

    // Reset with 3 buffered and 2 in flight.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; issue_en = 1'b0;
      in_a = 64'(200 + i); in_b = '0; in_c = '0;
      tick();
    end
    issue_en = 1'b1; in_a = 64'd300;
    tick();
    tick();
    chk("C_pre_level", level, 3);
    chk("C_pre_iss_valid", iss_valid, 1);
    Rst = 1'b1; in_valid = 1'b0; issue_en = 1'b1;
    #1;
    chk("C_rst_ready", in_ready, 0);
    tick();
    Rst = 1'b0;
    chk("C_level", level, 0);
    chk("C_iss_valid", iss_valid, 0);
    chk("C_a", a, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("C_ready", in_ready, 1);
      tick();
      chk("C_no_res", res_valid, 0);
      chk("C_level_idle", level, 0);
    end
    in_valid = 1'b1; in_a = 64'd77; in_b = 64'd78; in_c = 64'd79;
    tick();
    in_valid = 1'b0;
    tick();
    chk("C_new_iss_valid", iss_valid, 1);
    chk("C_new_tag", iss_tag, 0);
    chk("C_new_a", a, 77);
    tick();
    chk("C_res_early", res_valid, 0);
    tick();
    chk("C_res_valid", res_valid, 1);
    chk("C_res_tag", res_tag, 0);
    tick();
    chk("C_res_once", res_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/circuit4_operand_issue.md
# circuit4_operand_issue

Upstream feed stage for the Circuit4 datapath. Accepts operand triples (a, b, c) over a valid/ready handshake and buffers them in a small FIFO. Issues one triple per cycle onto the datapath's registered a/b/c inputs. Tracks the datapath's fixed 2-register latency with a valid/tag delay line, so consumers know exactly which cycle carries a fresh x/z result and which triple produced it.

## Interface
- DATAWIDTH, 64, operand width; matches the datapath's a/b/c inputs
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- LATENCY, 2, register stages between datapath a/b/c inputs and x/z outputs
- TAGW, 4, width of the issue sequence tag

Ports:
- Clk  input  1  rising-edge clock; the block's only clock
- Rst  input  1  reset; synchronous and active-high
- in_valid  input  1  producer has a triple on in_a/in_b/in_c
- in_ready  output  1  FIFO can accept this cycle
- in_a, in_b, in_c  input  DATAWIDTH  operand triple
- issue_en  input  1  issue permitted this cycle; 0 pauses draining
- a, b, c  output  DATAWIDTH  registered operands to the datapath
- iss_valid  output  1  a/b/c were loaded at the last edge
- iss_tag  output  TAGW  tag of the triple on a/b/c
- res_valid  output  1  datapath x/z hold the result of a triple issued LATENCY edges earlier
- res_tag  output  TAGW  tag matching the current x/z
- level  output  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

## Operation
- Push: occurs at an edge when in_valid && in_ready.
  - in_ready = (level < DEPTH) && !Rst. It is computed from registered level only, so a pop in the same cycle does not free a slot early.
- Pop/issue: occurs at an edge when level > 0 && issue_en.
  - a/b/c <= FIFO head.
  - iss_valid <= 1.
  - iss_tag <= tag counter; the tag counter then increments mod 2^TAGW.
- No issue at an edge:
  - a/b/c hold their previous value; the datapath recomputes the same result.
  - iss_valid <= 0.
- No bypass: a triple pushed into an empty FIFO issues no earlier than the following edge.
- Simultaneous push and pop: level unchanged. Data order is strict FIFO.
- Read and write pointers wrap modulo DEPTH. level distinguishes full from empty.
- Delay line: LATENCY-stage shift register of {iss_valid, iss_tag}, clocked every cycle (no stall).
  - res_valid/res_tag are the last stage.
  - res_tag is only meaningful when res_valid=1; otherwise it holds the last shifted value.

## Timing
- Reset (Rst high at an edge):
  - Outputs: a/b/c = 0, iss_valid = 0, iss_tag = 0, res_valid = 0, res_tag = 0, level = 0.
  - Internal: tag counter = 0, pointers = 0, delay line cleared.
  - in_ready = 0 while Rst is high, 1 in the first cycle after.
- Reset mid-operation: all buffered triples and in-flight valids are discarded. No res_valid pulse may appear after reset for a triple issued before it.
- Accept at edge k into an empty FIFO with issue_en=1:
  - a/b/c updated at edge k+1.
  - res_valid high in the cycle after edge k+1+LATENCY (edge k+3 for the default).
- Throughput: one triple per cycle sustained when DEPTH ≥ 2 and issue_en stays high.
- Full FIFO: in_ready is low for the whole cycle. A pop in that cycle raises in_ready only in the next cycle.
- issue_en low: FIFO fills to DEPTH, then in_ready drops. res_valid goes low LATENCY cycles after the last issue.

## Test plan
- Reset, then push (a=5, b=3, c=7) with issue_en=1:
  - a/b/c = 5/3/7 and iss_tag=0 one edge after acceptance.
  - res_valid=1 with res_tag=0 exactly 2 edges later, for exactly one cycle.
- Push 4 triples with issue_en=0:
  - level reaches 4, in_ready=0, a 5th in_valid is not accepted.
  - Raise issue_en: the triples issue in push order on consecutive cycles with tags 0..3. level steps 4→0.
- Full FIFO with in_valid held high and issue_en=1:
  - The pop cycle does not accept.
  - Next cycle accepts. level alternates correctly, with no loss or duplication across 20 triples.
- Issue 18 triples: iss_tag wraps 15→0, and res_tag follows the same sequence delayed 2 cycles.
- Assert Rst for one cycle with 3 triples buffered and 2 in flight:
  - level=0.
  - No res_valid pulse for the next 4 cycles.
  - The next pushed triple issues with tag 0.
- Idle gap of 5 cycles between pushes:
  - a/b/c hold the last triple.
  - iss_valid and res_valid are low throughout the gap (after the 2-cycle tail).
